neuron_compute_layer1_12: RTL and testbench
===========================================

# neuron_compute_layer1_12

Layer-1 neuron compute stage. Consumes the flat bias vector and the flat weight vector produced by the layer-1 BRAM loaders. Runs a sequential multiply-accumulate over the input activations, adds bias, applies ReLU and saturation, and presents a flat activation vector to layer 2. It also issues the start pulse that launches both loaders.

## Interface
Parameters:
- IN_SIZE, 1, inputs per neuron
- OUT_SIZE, 8, neurons in this layer
- W, 8, signed data width of activations, weights, bias and outputs
- FRAC_BITS, 4, fixed-point fraction bits (Q format shared by all operands)
- TOTAL_WEIGHTS, IN_SIZE*OUT_SIZE, weight count

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to compute the layer
- x_in  in  IN_SIZE*W  input activations; element i at [i*W +: W]
- load_start  out  1  one-cycle pulse to the bias and weight loaders
- bias_vec  in  OUT_SIZE*W  bias; element o at [o*W +: W]
- bias_done  in  1  bias loader done (level)
- weight_vec  in  TOTAL_WEIGHTS*W  weights; weight(o,i) at [(o*IN_SIZE+i)*W +: W]
- weight_done  in  1  weight loader done (level)
- data_out  out  OUT_SIZE*W  activations; neuron o at [o*W +: W]
- busy  out  1  high in LOAD, MAC, BIAS
- done  out  1  high in DONE

## Operation
- Reset values: state IDLE; data_out 0; acc 0; counters 0; load_start 0; busy 0; done 0.
- IDLE: on start, drive load_start=1 for one cycle and go to LOAD.
- LOAD: wait until bias_done && weight_done are both high in the same cycle. Then clear acc, i=0, o=0, and go to MAC.
- MAC: each cycle, acc += sext(x_in[i]) * sext(weight(o,i)).
  - If i==IN_SIZE-1, go to BIAS.
  - Otherwise, i++.
- BIAS: sum = acc + (sext(bias[o]) <<< FRAC_BITS); y = sum >>> FRAC_BITS (arithmetic shift, truncate).
  - Clamp y to [0, 2^(W-1)-1]: negative becomes 0 (ReLU), overflow becomes 127 for W=8.
  - Write data_out[o]. Clear acc and i.
  - If o==OUT_SIZE-1, go to DONE. Otherwise, o++ and go to MAC.
- DONE: data_out holds its value. A start pulse clears done, issues load_start and re-enters LOAD. data_out keeps its old values until overwritten neuron by neuron.
- start is ignored in LOAD, MAC and BIAS.
- Accumulator width: ACC_W = 2*W + clog2(IN_SIZE+1) + 1 signed. It must never wrap for any operand values.
- x_in, bias_vec and weight_vec are sampled live, not captured. Upstream holds them stable from the done level until the next load_start.

## Timing
- load_start is asserted the cycle after start is sampled in IDLE/DONE.
- LOAD to first MAC: 1 cycle after both done levels are seen high.
- Compute latency, from the first MAC cycle to done=1: exactly OUT_SIZE*(IN_SIZE+1) cycles. With defaults that is 16.
- data_out[o] updates on the clock edge that ends that neuron's BIAS cycle. done rises on the edge that ends the final BIAS cycle.
- rst during any state: next cycle everything is at its reset values, and no load_start is emitted.
- Both done levels already high when LOAD is entered, e.g. stale from a prior run: the block proceeds immediately. Loaders are required to drop done within one cycle of load_start, so this check actually happens the cycle after load_start.
- start coincident with rst: rst wins.

## Structure
- Shared package neuron_pkg:
  - state encodings IDLE/LOAD/MAC/BIAS/DONE (3-bit)
  - ACC_W width function
  - SAT_MAX constant derived from W
- Sub-module neuron_postproc (combinational): inputs acc and bias; performs bias alignment, shift, ReLU and clamp; outputs the W-bit y. It is reused by later layers.
- Top: FSM, i/o counters, accumulator, data_out register.

## Test plan
- FRAC=4, x=16, all w=32, all bias=8 → each data_out element = 40. done is seen 16 cycles after leaving LOAD.
- w=-32, bias=0 → all outputs 0 (ReLU). w=-32, bias=40 → sum −512+640=128, output 8.
- x=127, w=127, bias=127 → 16129+2032 then >>>4 = 1135 → clamped to 127.
- Hold bias_done low 10 cycles after load_start while weight_done is high → the block stays in LOAD, busy=1, no data_out change. It proceeds one cycle after bias_done rises.
- Assert rst in the third MAC cycle → next cycle data_out=0, done=0, busy=0, state IDLE. A fresh start then completes normally.
- From DONE, pulse start with new bias=0 → load_start pulses, done drops, and the rerun produces the new values (x=16, w=32 → 32).

Source files
------------

// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared state encoding and width helpers for the neuron compute layers
package neuron_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MAC  = 3'd2,
        ST_BIAS = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Wide enough that a full dot product plus aligned bias can never wrap
    function automatic int acc_width(input int w, input int in_size);
        return 2 * w + $clog2(in_size + 1) + 1;
    endfunction

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/neuron_compute_layer1_12_if.sv
// rtl/neuron_compute_layer1_12_if.sv - request, loader and result signals of the layer-1 compute stage
interface neuron_compute_layer1_12_if #(
    parameter int IN_SIZE  = 1,
    parameter int OUT_SIZE = 8,
    parameter int W        = 8
);
    localparam int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE;

    logic                       start;
    logic [IN_SIZE*W-1:0]       x_in;
    logic                       load_start;
    logic [OUT_SIZE*W-1:0]      bias_vec;
    logic                       bias_done;
    logic [TOTAL_WEIGHTS*W-1:0] weight_vec;
    logic                       weight_done;
    logic [OUT_SIZE*W-1:0]      data_out;
    logic                       busy;
    logic                       done;

    modport master (
        output start, x_in, bias_vec, bias_done, weight_vec, weight_done,
        input  load_start, data_out, busy, done
    );

    modport slave (
        input  start, x_in, bias_vec, bias_done, weight_vec, weight_done,
        output load_start, data_out, busy, done
    );

endinterface

// File: rtl/neuron_postproc.sv
// rtl/neuron_postproc.sv - bias alignment, fraction shift, ReLU and saturation of one accumulator
module neuron_postproc
    import neuron_pkg::*;
#(
    parameter int W         = 8,
    parameter int FRAC_BITS = 4,
    parameter int ACC_W     = acc_width(8, 1)
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [W-1:0]     bias,
    output logic        [W-1:0]     y
);
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] SAT_LIM = SUM_W'(sat_max(W));

    logic signed [SUM_W-1:0] bias_al;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;

    always_comb begin
        bias_al = SUM_W'(bias) <<< FRAC_BITS;
        sum     = SUM_W'(acc) + bias_al;
        shifted = sum >>> FRAC_BITS;
        if (shifted < 0) begin
            y = '0;
        end else if (shifted > SAT_LIM) begin
            y = W'(SAT_LIM);
        end else begin
            y = W'(shifted);
        end
    end

endmodule

// File: rtl/neuron_compute_layer1_12.sv
// rtl/neuron_compute_layer1_12.sv - layer-1 sequential MAC neuron stage driving the layer-2 activation vector
module neuron_compute_layer1_12
    import neuron_pkg::*;
#(
    parameter int IN_SIZE       = 1,
    parameter int OUT_SIZE      = 8,
    parameter int W             = 8,
    parameter int FRAC_BITS     = 4,
    parameter int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE
) (
    input logic                       clk,
    input logic                       rst,
    neuron_compute_layer1_12_if.slave bus
);
    localparam int ACC_W = acc_width(W, IN_SIZE);
    localparam int IW    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int OW    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    state_t                  state;
    state_t                  state_nxt;
    logic [IW-1:0]           i_cnt;
    logic [OW-1:0]           o_cnt;
    logic signed [ACC_W-1:0] acc;
    logic [OUT_SIZE*W-1:0]   data_q;
    logic                    load_start_q;

    logic signed [W-1:0]        x_arr [2**IW];
    logic signed [W-1:0]        w_arr [2**OW][2**IW];
    logic signed [W-1:0]        b_arr [2**OW];
    logic [TOTAL_WEIGHTS*W-1:0] weight_flat;
    logic signed [2*W-1:0]      prod;
    logic [W-1:0]               y;
    logic                       last_i;
    logic                       last_o;
    logic                       loaded;
    logic                       launch;

    assign weight_flat = bus.weight_vec;

    // Power-of-two padded views so the counters index without range checks
    always_comb begin
        for (int a = 0; a < 2**OW; a++) begin
            b_arr[a] = '0;
            for (int b = 0; b < 2**IW; b++) begin
                w_arr[a][b] = '0;
            end
        end
        for (int b = 0; b < 2**IW; b++) begin
            x_arr[b] = '0;
        end
        for (int b = 0; b < IN_SIZE; b++) begin
            x_arr[b] = bus.x_in[b*W +: W];
        end
        for (int a = 0; a < OUT_SIZE; a++) begin
            b_arr[a] = bus.bias_vec[a*W +: W];
            for (int b = 0; b < IN_SIZE; b++) begin
                w_arr[a][b] = weight_flat[(a*IN_SIZE+b)*W +: W];
            end
        end
    end

    assign prod   = x_arr[i_cnt] * w_arr[o_cnt][i_cnt];
    assign last_i = (i_cnt == IW'(IN_SIZE - 1));
    assign last_o = (o_cnt == OW'(OUT_SIZE - 1));
    assign loaded = bus.bias_done && bus.weight_done;
    assign launch = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                bus.busy = 1'b1;
                if (loaded) state_nxt = ST_MAC;
            end
            ST_MAC: begin
                bus.busy = 1'b1;
                if (last_i) state_nxt = ST_BIAS;
            end
            ST_BIAS: begin
                bus.busy  = 1'b1;
                state_nxt = last_o ? ST_DONE : ST_MAC;
            end
            ST_DONE: begin
                bus.done = 1'b1;
                if (bus.start) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            i_cnt        <= '0;
            o_cnt        <= '0;
            acc          <= '0;
            data_q       <= '0;
            load_start_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            load_start_q <= launch;
            unique case (state)
                ST_LOAD: begin
                    if (loaded) begin
                        acc   <= '0;
                        i_cnt <= '0;
                        o_cnt <= '0;
                    end
                end
                ST_MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (!last_i) i_cnt <= i_cnt + IW'(1);
                end
                ST_BIAS: begin
                    data_q[int'(o_cnt)*W +: W] <= y;
                    acc   <= '0;
                    i_cnt <= '0;
                    if (!last_o) o_cnt <= o_cnt + OW'(1);
                end
                default: ;
            endcase
        end
    end

    neuron_postproc #(
        .W         (W),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_postproc (
        .acc  (acc),
        .bias (b_arr[o_cnt]),
        .y    (y)
    );

    assign bus.load_start = load_start_q;
    assign bus.data_out   = data_q;

endmodule

// File: tb/tb_neuron_compute_layer1_12.sv
// tb/tb_neuron_compute_layer1_12.sv - directed table-driven bench for the layer-1 neuron compute stage
module tb_neuron_compute_layer1_12;
    localparam int IN_SIZE   = 1;
    localparam int OUT_SIZE  = 8;
    localparam int W         = 8;
    localparam int FRAC_BITS = 4;
    localparam int LAT       = OUT_SIZE * (IN_SIZE + 1) + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    neuron_compute_layer1_12_if #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .W(W)) bus ();

    neuron_compute_layer1_12 #(
        .IN_SIZE   (IN_SIZE),
        .OUT_SIZE  (OUT_SIZE),
        .W         (W),
        .FRAC_BITS (FRAC_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int x;
        int w;
        int b;
        int expv;
    } vec_t;

    vec_t vecs [12];
    logic [OUT_SIZE*W-1:0] expected_out;
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic issue_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("load_start_pulse", int'(bus.load_start), 1);
        chk("busy_in_load", int'(bus.busy), 1);
        chk("done_cleared", int'(bus.done), 0);
        bus.bias_done   = 1'b0;
        bus.weight_done = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat);
        int lat;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk("done_latency", lat, exp_lat);
    endtask

    task automatic run_vec(input logic [IN_SIZE*W-1:0] xflat, input logic [OUT_SIZE*W-1:0] wflat,
                           input logic [OUT_SIZE*W-1:0] bflat, input logic [OUT_SIZE*W-1:0] eflat,
                           input int bias_delay);
        issue_start();
        bus.x_in       = xflat;
        bus.weight_vec = wflat;
        bus.bias_vec   = bflat;
        @(negedge clk);
        chk("load_start_drop", int'(bus.load_start), 0);
        bus.weight_done = 1'b1;
        bus.bias_done   = (bias_delay == 0);
        for (int c = 0; c < bias_delay; c++) begin
            bus.start = (c == 3);
            @(negedge clk);
            chk("load_wait_busy", int'(bus.busy), 1);
            chk("load_wait_data_held", int'(bus.data_out == expected_out), 1);
            chk("load_wait_no_relaunch", int'(bus.load_start), 0);
        end
        bus.start     = 1'b0;
        bus.bias_done = 1'b1;
        wait_done(LAT);
        for (int o = 0; o < OUT_SIZE; o++) begin
            chk($sformatf("data_out[%0d]", o), int'(bus.data_out[o*W +: W]), int'(eflat[o*W +: W]));
        end
        chk("busy_after_done", int'(bus.busy), 0);
        expected_out = eflat;
    endtask

    initial begin
        logic [IN_SIZE*W-1:0]  xf;
        logic [OUT_SIZE*W-1:0] wf;
        logic [OUT_SIZE*W-1:0] bf;
        logic [OUT_SIZE*W-1:0] ef;

        vecs[0]  = '{16, 32, 8, 40};
        vecs[1]  = '{16, 32, 0, 32};
        vecs[2]  = '{16, -32, 0, 0};
        vecs[3]  = '{16, -32, 40, 8};
        vecs[4]  = '{127, 127, 127, 127};
        vecs[5]  = '{-128, -128, 0, 127};
        vecs[6]  = '{-16, 32, 127, 95};
        vecs[7]  = '{3, -7, 2, 0};
        vecs[8]  = '{24, 24, -1, 35};
        vecs[9]  = '{-1, 1, 0, 0};
        vecs[10] = '{127, 16, 0, 127};
        vecs[11] = '{127, 16, 1, 127};

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.x_in        = '0;
        bus.bias_vec    = '0;
        bus.weight_vec  = '0;
        bus.bias_done   = 1'b0;
        bus.weight_done = 1'b0;
        expected_out    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_data_out", int'(bus.data_out != '0), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_load_start", int'(bus.load_start), 0);

        for (int v = 0; v < 12; v++) begin
            xf = {IN_SIZE{W'(vecs[v].x)}};
            wf = {OUT_SIZE{W'(vecs[v].w)}};
            bf = {OUT_SIZE{W'(vecs[v].b)}};
            ef = {OUT_SIZE{W'(vecs[v].expv)}};
            run_vec(xf, wf, bf, ef, 0);
        end

        // bias loader late by 10 cycles while weights are ready
        run_vec({IN_SIZE{W'(16)}}, {OUT_SIZE{W'(32)}}, {OUT_SIZE{W'(8)}}, {OUT_SIZE{W'(40)}}, 10);

        // per-neuron weights 16*o exercise the neuron indexing
        for (int o = 0; o < OUT_SIZE; o++) begin
            wf[o*W +: W] = W'(16 * o);
            ef[o*W +: W] = W'(16 * o);
        end
        run_vec({IN_SIZE{W'(16)}}, wf, {OUT_SIZE{W'(0)}}, ef, 0);

        // reset during the third MAC cycle, with start coincident with reset
        issue_start();
        bus.x_in       = {IN_SIZE{W'(16)}};
        bus.weight_vec = {OUT_SIZE{W'(32)}};
        bus.bias_vec   = {OUT_SIZE{W'(8)}};
        @(negedge clk);
        bus.bias_done   = 1'b1;
        bus.weight_done = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_run_busy", int'(bus.busy), 1);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        chk("rst_data_out", int'(bus.data_out != '0), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_load_start", int'(bus.load_start), 0);
        @(negedge clk);
        chk("rst_start_ignored", int'(bus.load_start), 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", int'(bus.busy), 0);
        expected_out = '0;
        run_vec({IN_SIZE{W'(16)}}, {OUT_SIZE{W'(32)}}, {OUT_SIZE{W'(8)}}, {OUT_SIZE{W'(40)}}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
